// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-register fields and the init/refresh FSM states.
package sdram_pkg;

  // Command bus encoding {RASn, CASn, WEn}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;

  localparam logic [2:0] MODE_CL2    = 3'd2;
  localparam logic       MODE_BT_SEQ = 1'b0;
  localparam logic [2:0] MODE_BL1    = 3'd0;

  localparam logic [10:0] MODE_REG_DEFAULT = {4'b0000, MODE_CL2, MODE_BT_SEQ, MODE_BL1};

  // A10 high on PRECHARGE selects all banks
  localparam logic [10:0] A_ALL_BANKS = 11'h400;

  typedef enum logic [3:0] {
    StInitWait,
    StPre,
    StWaitRp,
    StIref,
    StWaitIrfc,
    StLmr,
    StWaitMrd,
    StIdle,
    StReq,
    StRef,
    StWaitRfc
  } sdram_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval down-counter with pending flag (or debt counter when SDRAM_REF_DEBT_EN
// is defined) and sticky overrun.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 390
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic consume,
  output logic pending,
  output logic overrun
);

  localparam int unsigned TW = ($clog2(REF_INTERVAL) < 1) ? 1 : $clog2(REF_INTERVAL);
  localparam logic [TW-1:0] RELOAD = TW'(REF_INTERVAL - 1);

  logic          run_q;
  logic [TW-1:0] tmr_q;
  logic          expire;
  logic          overrun_d;

  assign expire = run_q && (tmr_q == '0);

  // Free-running once started so cadence does not depend on grant latency
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q <= 1'b0;
      tmr_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      tmr_q <= RELOAD;
    end else if (run_q) begin
      tmr_q <= expire ? RELOAD : tmr_q - 1'b1;
    end
  end

`ifdef SDRAM_REF_DEBT_EN
  logic [2:0] debt_q, debt_d;

  always_comb begin
    debt_d    = debt_q;
    overrun_d = overrun;
    if (expire && !consume) begin
      if (debt_q == 3'd7) overrun_d = 1'b1;
      else                debt_d    = debt_q + 3'd1;
    end else if (!expire && consume && (debt_q != 3'd0)) begin
      debt_d = debt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      debt_q  <= 3'd0;
      overrun <= 1'b0;
    end else begin
      debt_q  <= debt_d;
      overrun <= overrun_d;
    end
  end

  assign pending = (debt_q != 3'd0);
`else
  logic pend_q, pend_d;

  // A refresh being issued on the expiry edge absorbs the old request, so no overrun then
  always_comb begin
    pend_d    = pend_q;
    overrun_d = overrun;
    if (expire) begin
      pend_d = 1'b1;
      if (pend_q && !consume) overrun_d = 1'b1;
    end else if (consume) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      overrun <= overrun_d;
    end
  end

  assign pending = pend_q;
`endif

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialiser and auto-refresh scheduler; owns the command bus during init and
// refresh. Optional SDRAM_REF_DEBT_EN batches missed refreshes into one grant.
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int unsigned  T_INIT         = 2500,
  parameter int unsigned  T_RP           = 2,
  parameter int unsigned  T_RFC          = 3,
  parameter int unsigned  T_MRD          = 2,
  parameter int unsigned  INIT_REFRESHES = 2,
  parameter int unsigned  REF_INTERVAL   = 390,
  parameter logic [10:0]  MODE_REG       = MODE_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ref_gnt,
  output logic        ref_req,
  output logic        ref_done,
  output logic        ready,
  output logic        bus_own,
  output logic        ref_overrun,
  output logic [2:0]  sdram_cmd,
  output logic [10:0] sdram_a,
  output logic        sdram_ba
);

  // Wait states last T_x-1 cycles, so T_RP, T_RFC and T_MRD must be at least 2
  localparam logic [15:0] INIT_LAST = 16'(T_INIT - 1);
  localparam logic [15:0] RP_LAST   = 16'(T_RP - 2);
  localparam logic [15:0] RFC_LAST  = 16'(T_RFC - 2);
  localparam logic [15:0] MRD_LAST  = 16'(T_MRD - 2);
  localparam logic [7:0]  NUM_IREF  = 8'(INIT_REFRESHES);

  sdram_state_e state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   iref_q, iref_d;

  logic [2:0]   cmd_d;
  logic [10:0]  a_d;
  logic         ba_d;
  logic         ready_d;
  logic         bus_own_d;
  logic         ref_req_d;
  logic         ref_done_d;

  logic         timer_start;
  logic         consume;
  logic         pending;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .start   (timer_start),
    .consume (consume),
    .pending (pending),
    .overrun (ref_overrun)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iref_d  = iref_q;

    unique case (state_q)
      StInitWait: begin
        if (cnt_q == INIT_LAST) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StPre: begin
        state_d = StWaitRp;
        cnt_d   = '0;
      end
      StWaitRp: begin
        if (cnt_q == RP_LAST) begin
          state_d = StIref;
          iref_d  = 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIref: begin
        state_d = StWaitIrfc;
        cnt_d   = '0;
      end
      StWaitIrfc: begin
        if (cnt_q == RFC_LAST) begin
          if (iref_q >= NUM_IREF) begin
            state_d = StLmr;
          end else begin
            state_d = StIref;
            iref_d  = iref_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLmr: begin
        state_d = StWaitMrd;
        cnt_d   = '0;
      end
      StWaitMrd: begin
        if (cnt_q == MRD_LAST) state_d = StIdle;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      StIdle: begin
        if (pending) state_d = StReq;
      end
      StReq: begin
        if (ref_gnt) state_d = StRef;
      end
      StRef: begin
        state_d = StWaitRfc;
        cnt_d   = '0;
      end
      StWaitRfc: begin
        if (cnt_q == RFC_LAST) begin
`ifdef SDRAM_REF_DEBT_EN
          state_d = pending ? StRef : StIdle;
`else
          state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StInitWait;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    cmd_d      = CMD_NOP;
    a_d        = '0;
    ba_d       = 1'b0;
    bus_own_d  = 1'b1;
    ref_req_d  = 1'b0;
    ready_d    = ready | (state_d == StIdle);
    ref_done_d = (state_q == StWaitRfc) && (state_d == StIdle);

    case (state_d)
      StPre: begin
        cmd_d = CMD_PRE;
        a_d   = A_ALL_BANKS;
      end
      StIref, StRef: cmd_d = CMD_REF;
      StLmr: begin
        cmd_d = CMD_LMR;
        a_d   = MODE_REG;
      end
      StIdle: bus_own_d = 1'b0;
      StReq: begin
        bus_own_d = 1'b0;
        ref_req_d = 1'b1;
      end
      default: ;
    endcase

    timer_start = (state_q == StWaitMrd) && (state_d == StIdle);
    consume     = (state_d == StRef);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StInitWait;
      cnt_q     <= '0;
      iref_q    <= '0;
      sdram_cmd <= CMD_NOP;
      sdram_a   <= '0;
      sdram_ba  <= 1'b0;
      ready     <= 1'b0;
      bus_own   <= 1'b1;
      ref_req   <= 1'b0;
      ref_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iref_q    <= iref_d;
      sdram_cmd <= cmd_d;
      sdram_a   <= a_d;
      sdram_ba  <= ba_d;
      ready     <= ready_d;
      bus_own   <= bus_own_d;
      ref_req   <= ref_req_d;
      ref_done  <= ref_done_d;
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Cycle-accurate bench for sdram_init_refresh: per-cycle expected outputs queued as a scoreboard.
module tb_sdram_init_refresh;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ref_gnt;
  logic        ref_req, ref_done, ready, bus_own, ref_overrun;
  logic [2:0]  sdram_cmd;
  logic [10:0] sdram_a;
  logic        sdram_ba;

  always #5 clk = ~clk;

  sdram_init_refresh #(
    .T_INIT         (10),
    .T_RP           (2),
    .T_RFC          (3),
    .T_MRD          (2),
    .INIT_REFRESHES (2),
    .REF_INTERVAL   (20)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ref_gnt     (ref_gnt),
    .ref_req     (ref_req),
    .ref_done    (ref_done),
    .ready       (ready),
    .bus_own     (bus_own),
    .ref_overrun (ref_overrun),
    .sdram_cmd   (sdram_cmd),
    .sdram_a     (sdram_a),
    .sdram_ba    (sdram_ba)
  );

  typedef struct {
    int          cyc;
    logic [19:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    int          off;
    logic [2:0]  cmd;
    logic [10:0] a;
  } init_vec_t;

  sb_t       sb[$];
  init_vec_t init_tab[4];
  int        checks   = 0;
  int        failures = 0;
  int        cyc      = -1;
  int        nref;

  // {cmd, a, ba, ready, bus_own, ref_req, ref_done, ref_overrun}
  function automatic logic [19:0] pack(logic [2:0] cmd, logic [10:0] a, logic rdy, logic bo,
                                       logic rq, logic dn, logic ov);
    return {cmd, a, 1'b0, rdy, bo, rq, dn, ov};
  endfunction

  task automatic expect_at(int c, logic [19:0] v, string nm);
    sb.push_back('{c, v, nm});
  endtask

  task automatic step();
    logic [19:0] act;
    sb_t         e;
    @(negedge clk);
    cyc++;
    act = {sdram_cmd, sdram_a, sdram_ba, ready, bus_own, ref_req, ref_done, ref_overrun};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h (due cyc %0d)", e.name, cyc, act, e.exp, e.cyc);
      end
    end
  endtask

  // Queues the init sequence from reset edge b, then steps through it with gnt pulsed
  task automatic do_init(int b);
    logic [2:0]  cmd;
    logic [10:0] a;
    for (int off = 0; off <= 20; off++) begin
      cmd = CMD_NOP;
      a   = '0;
      foreach (init_tab[i]) begin
        if (init_tab[i].off == off) begin
          cmd = init_tab[i].cmd;
          a   = init_tab[i].a;
        end
      end
      expect_at(b + off, pack(cmd, a, off == 20, off != 20, 1'b0, 1'b0, 1'b0),
                $sformatf("init+%0d", off));
    end
    step();
    resetn = 1'b1;
    for (int off = 1; off <= 20; off++) begin
      ref_gnt = (off >= 3 && off <= 5);
      step();
    end
    ref_gnt = 1'b0;
  endtask

  initial begin
    int          rr[3] = '{41, 61, 81};
    int          d;
    logic [2:0]  cmd;
    logic        bo, rq, dn, ov;

    init_tab[0] = '{10, CMD_PRE, 11'h400};
    init_tab[1] = '{12, CMD_REF, 11'h000};
    init_tab[2] = '{15, CMD_REF, 11'h000};
    init_tab[3] = '{18, CMD_LMR, 11'h020};

    resetn  = 1'b0;
    ref_gnt = 1'b0;
    repeat (2) @(negedge clk);
    cyc = -1;
    do_init(0);

    // Periodic refresh with grant tied high from cycle 30; stray grant at 26 while idle
    for (int c = 21; c <= 83; c++) begin
      cmd = CMD_NOP; bo = 1'b0; rq = 1'b0; dn = 1'b0;
      foreach (rr[i]) begin
        d = c - rr[i];
        if (d == 0) rq = 1'b1;
        if (d == 1) begin cmd = CMD_REF; bo = 1'b1; end
        if (d == 2 || d == 3) bo = 1'b1;
        if (d == 4) dn = 1'b1;
      end
      expect_at(c, pack(cmd, 11'h000, 1'b1, bo, rq, dn, 1'b0), $sformatf("refresh@%0d", c));
    end
    for (int c = 21; c <= 83; c++) begin
      ref_gnt = (c == 26) || (c >= 30);
      step();
    end

    // One-cycle reset inside WAIT_RFC restarts the whole init sequence
    resetn  = 1'b0;
    ref_gnt = 1'b0;
    do_init(84);

`ifdef SDRAM_REF_DEBT_EN
    // Three expiries accumulate as debt; one grant drains it back-to-back
    for (int c = 105; c <= 183; c++) begin
      rq  = (c >= 125 && c <= 170);
      cmd = (c == 171 || c == 174 || c == 177) ? CMD_REF : CMD_NOP;
      bo  = (c >= 171 && c <= 179);
      dn  = (c == 180);
      expect_at(c, pack(cmd, 11'h000, 1'b1, bo, rq, dn, 1'b0), $sformatf("debt@%0d", c));
    end
    nref = 0;
    for (int c = 105; c <= 183; c++) begin
      ref_gnt = (c == 171);
      step();
      if (c >= 171 && sdram_cmd == CMD_REF) nref++;
    end
    checks++;
    if (nref != 3) begin
      failures++;
      $display("FAIL debt_ref_count got=%0d want=3", nref);
    end
`else
    // Grant withheld past a second expiry: overrun, request held, single REF on grant
    for (int c = 105; c <= 164; c++) begin
      rq  = (c >= 125 && c <= 155);
      ov  = (c >= 144);
      cmd = (c == 156) ? CMD_REF : CMD_NOP;
      bo  = (c >= 156 && c <= 158);
      dn  = (c == 159);
      expect_at(c, pack(cmd, 11'h000, 1'b1, bo, rq, dn, ov), $sformatf("overrun@%0d", c));
    end
    nref = 0;
    for (int c = 105; c <= 164; c++) begin
      ref_gnt = (c == 156);
      step();
      if (c >= 156 && sdram_cmd == CMD_REF) nref++;
    end
    checks++;
    if (nref != 1) begin
      failures++;
      $display("FAIL overrun_ref_count got=%0d want=1", nref);
    end
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0 entries left", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
